// File: rtl/dual_port_blockram.sv
// ============================================================================
//  Module   : dual_port_blockram
//  Brief    : Simple dual-port byte-masked block RAM with a post-reset clear
//             sequencer, 1- or 2-cycle read latency and optional write bypass.
//  Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module dual_port_blockram #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS,
    parameter int READ_LATENCY              = 1,
    parameter int BYPASS_EN                 = 1
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    output logic                                 init_done_out,
    input  logic [WRITE_MASK_LEN-1:0]            write_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     write_set_addr_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] write_entry_in,
    input  logic                                 read_en_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     read_set_addr_in,
    output logic                                 read_valid_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] read_entry_out
);

    localparam int c_BYTE_LEN = `BYTE_LEN_IN_BITS;
    localparam int c_DW       = SINGLE_ENTRY_SIZE_IN_BITS;
    localparam int c_AW       = SET_PTR_WIDTH_IN_BITS;
    localparam logic [c_AW-1:0] c_LAST_SET = c_AW'(NUM_SET - 1);

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_read_latency
            $error("dual_port_blockram: READ_LATENCY must be 1 or 2");
        end
        if ((c_DW % c_BYTE_LEN) != 0 || (WRITE_MASK_LEN * c_BYTE_LEN) != c_DW) begin : g_bad_entry_width
            $error("dual_port_blockram: entry width must be a whole number of bytes");
        end
        if (NUM_SET < 2 || (1 << c_AW) < NUM_SET) begin : g_bad_num_set
            $error("dual_port_blockram: NUM_SET / SET_PTR_WIDTH_IN_BITS inconsistent");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_INIT  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    logic [c_DW-1:0] r_mem [0:NUM_SET-1];

    state_t              r_state_q,      w_state_d;
    logic [c_AW-1:0]     r_clr_cnt_q,    w_clr_cnt_d;
    logic                r_init_done_q,  w_init_done_d;
    logic                r_s1_valid_q,   w_s1_valid_d;
    logic [c_DW-1:0]     r_s1_data_q,    w_s1_data_d;
    logic                r_rd_valid_q,   w_rd_valid_d;
    logic [c_DW-1:0]     r_rd_data_q,    w_rd_data_d;

    logic                      w_wr_in_range;
    logic                      w_rd_in_range;
    logic                      w_usr_we;
    logic                      w_rd_fire;
    logic                      w_collide;
    logic                      w_mem_we;
    logic [c_AW-1:0]           w_mem_addr;
    logic [c_DW-1:0]           w_mem_data;
    logic [WRITE_MASK_LEN-1:0] w_mem_mask;
    logic [c_DW-1:0]           w_rd_raw;
    logic [c_DW-1:0]           w_rd_merged;

    // Addresses past NUM_SET only exist when NUM_SET is not a power of two.
    assign w_wr_in_range = (32'(write_set_addr_in) < 32'(NUM_SET));
    assign w_rd_in_range = (32'(read_set_addr_in)  < 32'(NUM_SET));

    assign w_usr_we  = !reset_in && (r_state_q == ST_READY) && (|write_en_in) && w_wr_in_range;
    assign w_rd_fire = !reset_in && (r_state_q == ST_READY) && read_en_in;
    assign w_collide = (BYPASS_EN != 0) && w_usr_we && (write_set_addr_in == read_set_addr_in);

    always_comb begin : p_ctrl
        w_state_d     = r_state_q;
        w_clr_cnt_d   = r_clr_cnt_q;
        w_init_done_d = r_init_done_q;
        w_mem_we      = 1'b0;
        w_mem_addr    = r_clr_cnt_q;
        w_mem_data    = '0;
        w_mem_mask    = '1;
        case (r_state_q)
            ST_RESET, ST_INIT: begin
                // The clear sequencer owns the single write port until done.
                w_mem_we    = 1'b1;
                w_clr_cnt_d = r_clr_cnt_q + c_AW'(1);
                if (r_clr_cnt_q == c_LAST_SET) begin
                    w_state_d     = ST_READY;
                    w_init_done_d = 1'b1;
                end else begin
                    w_state_d = ST_INIT;
                end
            end
            ST_READY: begin
                if (w_usr_we) begin
                    w_mem_we   = 1'b1;
                    w_mem_addr = write_set_addr_in;
                    w_mem_data = write_entry_in;
                    w_mem_mask = write_en_in;
                end
            end
            default: begin
                w_state_d = ST_RESET;
            end
        endcase
        if (reset_in) begin
            w_mem_we = 1'b0;
        end
    end

    always_comb begin : p_read_merge
        w_rd_raw    = w_rd_in_range ? r_mem[read_set_addr_in] : '0;
        w_rd_merged = w_rd_raw;
        if (w_collide) begin
            for (int i = 0; i < WRITE_MASK_LEN; i++) begin
                if (write_en_in[i]) begin
                    w_rd_merged[i*c_BYTE_LEN +: c_BYTE_LEN] = write_entry_in[i*c_BYTE_LEN +: c_BYTE_LEN];
                end
            end
        end
    end

    always_comb begin : p_pipe
        w_s1_valid_d = w_rd_fire;
        w_s1_data_d  = w_rd_fire ? w_rd_merged : r_s1_data_q;
        if (READ_LATENCY == 1) begin
            w_rd_valid_d = w_rd_fire;
            w_rd_data_d  = w_rd_fire ? w_rd_merged : r_rd_data_q;
        end else begin
            w_rd_valid_d = r_s1_valid_q;
            w_rd_data_d  = r_s1_valid_q ? r_s1_data_q : r_rd_data_q;
        end
    end

    always_ff @(posedge clk_in) begin : p_regs
        if (reset_in) begin
            r_state_q     <= ST_RESET;
            r_clr_cnt_q   <= '0;
            r_init_done_q <= 1'b0;
            r_s1_valid_q  <= 1'b0;
            r_s1_data_q   <= '0;
            r_rd_valid_q  <= 1'b0;
            r_rd_data_q   <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_clr_cnt_q   <= w_clr_cnt_d;
            r_init_done_q <= w_init_done_d;
            r_s1_valid_q  <= w_s1_valid_d;
            r_s1_data_q   <= w_s1_data_d;
            r_rd_valid_q  <= w_rd_valid_d;
            r_rd_data_q   <= w_rd_data_d;
        end
    end

    // Storage has no reset; contents are only zeroed by the clear sequencer.
    always_ff @(posedge clk_in) begin : p_mem
        if (w_mem_we) begin
            for (int i = 0; i < WRITE_MASK_LEN; i++) begin
                if (w_mem_mask[i]) begin
                    r_mem[w_mem_addr][i*c_BYTE_LEN +: c_BYTE_LEN] <= w_mem_data[i*c_BYTE_LEN +: c_BYTE_LEN];
                end
            end
        end
    end

    assign init_done_out  = r_init_done_q;
    assign read_valid_out = r_rd_valid_q;
    assign read_entry_out = r_rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dual_port_blockram.sv
// ============================================================================
//  Module   : tb_dual_port_blockram
//  Brief    : Scoreboard bench driving a latency-1/bypass and a
//             latency-2/no-bypass instance with the same directed vectors.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dual_port_blockram;

    localparam int DW = 64;
    localparam int AW = 6;
    localparam int ML = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [ML-1:0] wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [AW-1:0] raddr;

    logic          a_init_done, a_valid;
    logic [DW-1:0] a_data;
    logic          b_init_done, b_valid;
    logic [DW-1:0] b_data;

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dual_port_blockram #(
        .SINGLE_ENTRY_SIZE_IN_BITS(DW), .NUM_SET(64), .READ_LATENCY(1), .BYPASS_EN(1)
    ) dut_a (
        .clk_in(clk), .reset_in(rst), .init_done_out(a_init_done),
        .write_en_in(wen), .write_set_addr_in(waddr), .write_entry_in(wdata),
        .read_en_in(ren), .read_set_addr_in(raddr),
        .read_valid_out(a_valid), .read_entry_out(a_data)
    );

    dual_port_blockram #(
        .SINGLE_ENTRY_SIZE_IN_BITS(DW), .NUM_SET(64), .READ_LATENCY(2), .BYPASS_EN(0)
    ) dut_b (
        .clk_in(clk), .reset_in(rst), .init_done_out(b_init_done),
        .write_en_in(wen), .write_set_addr_in(waddr), .write_entry_in(wdata),
        .read_en_in(ren), .read_set_addr_in(raddr),
        .read_valid_out(b_valid), .read_entry_out(b_data)
    );

    // Monitors: every valid result must match the head of its queue, on its due cycle.
    always @(negedge clk) begin
        if (a_valid !== 1'b0) begin
            vectors++;
            if (qa.size() == 0) begin
                miscompares++;
                $display("FAIL a_read: unexpected valid at cycle %0d, got %h, required no result", cyc, a_data);
            end else begin
                ea = qa.pop_front();
                if (a_data !== ea.data || cyc != ea.due) begin
                    miscompares++;
                    $display("FAIL a_read: got %h at cycle %0d, required %h at cycle %0d", a_data, cyc, ea.data, ea.due);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (b_valid !== 1'b0) begin
            vectors++;
            if (qb.size() == 0) begin
                miscompares++;
                $display("FAIL b_read: unexpected valid at cycle %0d, got %h, required no result", cyc, b_data);
            end else begin
                eb = qb.pop_front();
                if (b_data !== eb.data || cyc != eb.due) begin
                    miscompares++;
                    $display("FAIL b_read: got %h at cycle %0d, required %h at cycle %0d", b_data, cyc, eb.data, eb.due);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic issue_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_a, input logic [DW-1:0] exp_b);
        ren   = 1'b1;
        raddr = a;
        qa.push_back('{data: exp_a, due: cyc + 1});
        qb.push_back('{data: exp_b, due: cyc + 2});
    endtask

    task automatic set_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [ML-1:0] m);
        wen   = m;
        waddr = a;
        wdata = d;
    endtask

    task automatic idle();
        ren = 1'b0;
        wen = '0;
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        waddr = '0;
        raddr = '0;
        wdata = '0;
        idle();
        tick();
        tick();
        chk("a_reset_init_done", a_init_done, 0);
        chk("b_reset_init_done", b_init_done, 0);
        chk("a_reset_valid", a_valid, 0);
        chk("b_reset_valid", b_valid, 0);
        chk("a_reset_data", a_data, 0);
        chk("b_reset_data", b_data, 0);

        // Clear phase: requests issued now must be ignored.
        rst = 1'b0;
        set_write(6'd62, '1, 8'hFF);
        ren   = 1'b1;
        raddr = 6'd62;
        for (int k = 1; k <= 64; k++) begin
            tick();
            chk("a_init_done", a_init_done, (k == 64));
            chk("b_init_done", b_init_done, (k == 64));
        end
        idle();

        for (int s = 0; s < 64; s++) begin
            issue_read(s[AW-1:0], 0, 0);
            tick();
        end
        idle();

        set_write(6'd63, 64'hFFFFFFFF00000000, 8'hFF);
        tick();
        idle();
        issue_read(6'd63, 64'hFFFFFFFF00000000, 64'hFFFFFFFF00000000);
        tick();
        idle();
        tick();
        chk("a_hold_data", a_data, 64'hFFFFFFFF00000000);

        set_write(6'd62, '1, 8'hCC);
        tick();
        idle();
        issue_read(6'd62, 64'hFFFF0000FFFF0000, 64'hFFFF0000FFFF0000);
        tick();
        idle();

        set_write(6'd5, 64'h1111111111111111, 8'hFF);
        tick();
        idle();
        set_write(6'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        issue_read(6'd5, 64'h11111111AAAAAAAA, 64'h1111111111111111);
        tick();
        idle();
        issue_read(6'd5, 64'h11111111AAAAAAAA, 64'h11111111AAAAAAAA);
        tick();
        idle();

        set_write(6'd1, 64'd1, 8'hFF);
        tick();
        set_write(6'd2, 64'd2, 8'hFF);
        tick();
        set_write(6'd3, 64'd3, 8'hFF);
        tick();
        idle();
        issue_read(6'd1, 64'd1, 64'd1);
        tick();
        issue_read(6'd2, 64'd2, 64'd2);
        tick();
        issue_read(6'd3, 64'd3, 64'd3);
        set_write(6'd2, 64'hDEAD, 8'hFF);
        tick();
        idle();
        issue_read(6'd2, 64'hDEAD, 64'hDEAD);
        tick();
        idle();
        repeat (3) tick();

        // Reset arrives on the same edge as a read: no result may appear.
        set_write(6'd10, 64'h55, 8'hFF);
        tick();
        idle();
        ren   = 1'b1;
        raddr = 6'd10;
        rst   = 1'b1;
        tick();
        idle();
        tick();
        chk("a_rereset_init_done", a_init_done, 0);
        chk("b_rereset_init_done", b_init_done, 0);
        rst = 1'b0;
        n   = 0;
        while (!(a_init_done === 1'b1 && b_init_done === 1'b1) && n < 200) begin
            tick();
            n++;
        end
        chk("reinit_edges", n, 64);

        issue_read(6'd10, 0, 0);
        tick();
        issue_read(6'd5, 0, 0);
        tick();
        idle();
        repeat (4) tick();
        chk("a_pending_results", qa.size(), 0);
        chk("b_pending_results", qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dual_port_blockram.md
Name: dual_port_blockram

Overview:
Parametrised simple dual-port block RAM: one write port and one read port, both usable in the same cycle. Supports byte-masked writes and a configurable read latency of 1 or 2. Optional write-to-read bypass on address collisions. A built-in clear sequencer zeroes the whole array after reset. Intended as the storage primitive for cache tag/data arrays that need concurrent fill and lookup.

Parameters:
SINGLE_ENTRY_SIZE_IN_BITS, 64, entry width; must be a multiple of `BYTE_LEN_IN_BITS
NUM_SET, 64, number of entries
SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET), address width
WRITE_MASK_LEN, SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS, byte-enable width
READ_LATENCY, 1, read latency in clock edges; legal values 1 or 2
BYPASS_EN, 1, 1 = same-cycle same-address read returns merged new data; 0 = returns old data

Ports:
clk_in  input  1  clock; all logic on the rising edge
reset_in  input  1  synchronous, active-high reset
init_done_out  output  1  high once the array clear has finished
write_en_in  input  WRITE_MASK_LEN  byte write enables; bit i covers byte i
write_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  write address
write_entry_in  input  SINGLE_ENTRY_SIZE_IN_BITS  write data
read_en_in  input  1  read request
read_set_addr_in  input  SET_PTR_WIDTH_IN_BITS  read address
read_valid_out  output  1  read_entry_out carries the result of a read
read_entry_out  output  SINGLE_ENTRY_SIZE_IN_BITS  read data

Behaviour:
- One clock (clk_in). Reset is synchronous and active-high (reset_in).
- Reset: while reset_in is high, sampled at the edge:
  - init_done_out=0, read_valid_out=0, read_entry_out=0.
  - The clear counter resets to 0.
  - All read-pipeline valid bits clear.
  - Array contents are untouched by reset itself.
- FSM: RESET -> INIT -> READY.
  - RESET: held while reset_in=1.
  - INIT:
    - On the k-th rising edge after reset_in falls (k=0..NUM_SET-1), set k is written with all zeros.
    - At the edge that writes set NUM_SET-1, the FSM enters READY and init_done_out goes to 1.
    - init_done_out is therefore high after exactly NUM_SET edges.
  - READY: normal operation.
  - reset_in=1 in any state returns to RESET, and a full re-clear follows. This includes reset asserted mid-INIT.
- During RESET and INIT, all external write and read requests are ignored. read_valid_out stays 0.
- Write (READY only):
  - At the edge, byte i of mem[write_set_addr_in] takes byte i of write_entry_in when write_en_in[i]=1.
  - Other bytes keep their old value.
  - write_en_in=0 is a no-op.
- Read (READY only):
  - read_en_in=1 samples read_set_addr_in at edge E.
  - Data and read_valid_out=1 are presented after edge E+READ_LATENCY-1, i.e. READ_LATENCY edges including E.
  - With READ_LATENCY=1, data is visible immediately after the sampling edge.
  - Back-to-back reads are fully pipelined, one result per cycle.
  - read_valid_out is high for exactly one cycle per request.
  - read_entry_out holds its last value when read_valid_out=0.
- Collision: read and write to the same address at the same edge:
  - BYPASS_EN=1: the result takes written bytes from write_entry_in and unwritten bytes from the old contents.
  - BYPASS_EN=0: the result is the full old contents.
- A write occurring after the read's sampling edge never alters that in-flight result. This holds for READ_LATENCY=2 as well.
- Different-address read and write at the same edge are independent.
- Address >= NUM_SET (non-power-of-2 NUM_SET only):
  - Writes are dropped.
  - Reads return 0 with read_valid_out=1.
- Elaboration error if READ_LATENCY is not 1 or 2, or if the width is not a byte multiple.

Test Plan:
1. Pulse reset_in for 2 cycles, then release -> init_done_out=0 for 63 edges and 1 after the 64th; reading sets 0..63 returns 0 each, one valid per cycle.
2. Write 0xFFFFFFFF00000000, mask 0xFF, to set 63; read set 63 on the next cycle -> read_valid_out=1 for one cycle with 0xFFFFFFFF00000000.
3. Set 62 holds 0; write all-ones with mask 8'b11001100; read set 62 -> 0xFFFF0000FFFF0000.
4. Set 5 holds 0x1111111111111111; on the same edge, write 0xAAAAAAAAAAAAAAAA with mask 0x0F and read set 5 -> 0x11111111AAAAAAAA with BYPASS_EN=1, 0x1111111111111111 with BYPASS_EN=0. On the next read, both configurations return 0x11111111AAAAAAAA.
5. READ_LATENCY=2, sets 1/2/3 hold 1/2/3; reads issued on 3 consecutive edges -> valid with data 1, 2, 3 on consecutive cycles, first valid one cycle later than the READ_LATENCY=1 case; a write to set 2 one edge after its read does not change the returned 2.
6. Write 0x55 to set 10, issue a read, and assert reset_in on the next edge -> read_valid_out stays 0; after re-INIT completes, reading set 10 returns 0.
